// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller and PC writer.
// Boots the PC from a two-word reset vector in instruction memory, then
// fetches 16-bit (bit0=0) or 32-bit (bit0=1, two words) instructions and
// hands each completed one to the IF/ID boundary with its address.
module pc_sequencer #(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] pc_q,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);

  localparam logic [1:0] BOOT0    = 2'd0;
  localparam logic [1:0] BOOT1    = 2'd1;
  localparam logic [1:0] FETCH    = 2'd2;
  localparam logic [1:0] FETCH_HI = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [15:0] boot_hi;
  logic [15:0] instr_hi;
  logic        take_boot;
  logic        take_hi;
  logic        done;
  logic [31:0] done_instr;
  logic [31:0] boot_vec;

  assign boot_vec = {boot_hi, imem_data};

  // Next-state, memory address and PC write decode; redirect beats stall.
  always_comb begin
    next_state = state;
    pc_we      = 1'b0;
    pc_next    = pc_q;
    imem_addr  = pc_q;
    take_boot  = 1'b0;
    take_hi    = 1'b0;
    done       = 1'b0;
    done_instr = '0;
    case (state)
      BOOT0: begin
        imem_addr  = RESET_VEC_ADDR;
        take_boot  = 1'b1;
        next_state = BOOT1;
      end
      BOOT1: begin
        imem_addr  = RESET_VEC_ADDR + ADDR_W'(1);
        pc_we      = 1'b1;
        pc_next    = ADDR_W'(boot_vec);
        next_state = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_we   = 1'b1;
          pc_next = redirect_pc;
        end else if (!stall) begin
          if (!imem_data[0]) begin
            done       = 1'b1;
            done_instr = {16'h0000, imem_data};
            pc_we      = 1'b1;
            pc_next    = pc_q + ADDR_W'(1);
          end else begin
            take_hi    = 1'b1;
            next_state = FETCH_HI;
          end
        end
      end
      FETCH_HI: begin
        imem_addr = pc_q + ADDR_W'(1);
        if (redirect) begin
          pc_we      = 1'b1;
          pc_next    = redirect_pc;
          next_state = FETCH;
        end else if (!stall) begin
          done       = 1'b1;
          done_instr = {instr_hi, imem_data};
          pc_we      = 1'b1;
          pc_next    = pc_q + ADDR_W'(2);
          next_state = FETCH;
        end
      end
      default: next_state = BOOT0;
    endcase
  end

  // Control state plus the boot-vector and instruction high-half latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT0;
      boot_hi  <= '0;
      instr_hi <= '0;
    end else begin
      state <= next_state;
      if (take_boot) boot_hi  <= imem_data;
      if (take_hi)   instr_hi <= imem_data;
    end
  end

  // IF/ID outputs: pulse valid on completion, otherwise hold instr/instr_pc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= done;
      if (done) begin
        instr    <= done_instr;
        instr_pc <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC register and small memory model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_q;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  logic [15:0] mem [256];
  logic [63:0] exp_q [$];
  int compared;
  int mismatched;

  pc_sequencer #(.ADDR_W(32), .RESET_VEC_ADDR(32'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc_q(pc_q), .pc_we(pc_we),
    .pc_next(pc_next), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory aliases on the low address byte; the test addresses do not collide.
  assign imem_data = mem[imem_addr[7:0]];

  initial pc_q = '0;
  always @(posedge clk) if (pc_we) pc_q <= pc_next;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic we, input logic [31:0] nxt,
                           input logic [31:0] addr);
    chk({tag, "_pc_we"}, 64'(pc_we), 64'(we));
    chk({tag, "_pc_next"}, 64'(pc_next), 64'(nxt));
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(addr));
  endtask

  // Scoreboard: every valid pulse must match the oldest expected instruction.
  always @(negedge clk) begin
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(instr_valid), 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("instr", 64'(instr), 64'(e[63:32]));
        chk("instr_pc", 64'(instr_pc), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0020;
    mem[8'h20] = 16'h1230; mem[8'h21] = 16'h4561; mem[8'h22] = 16'hBEEF;
    mem[8'h23] = 16'h0002; mem[8'h24] = 16'h7771; mem[8'h40] = 16'hABC0;
    mem[8'h50] = 16'h0100;
    stall = 0; redirect = 0; redirect_pc = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset state
    cyc(); #1;
    chk("rst_pc_we", 64'(pc_we), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    cyc();

    // Boot: vector 0x00000020
    rst = 1'b1; #1;
    chk_fetch("boot0", 1'b0, pc_q, 32'h0);
    cyc(); #1;
    chk_fetch("boot1", 1'b1, 32'h20, 32'h1);

    // Mixed stream: 16-bit at 0x20, then 32-bit at 0x21 with a 3-cycle stall
    cyc(); #1;
    chk_fetch("f16", 1'b1, 32'h21, 32'h20);
    exp_q.push_back({32'h00001230, 32'h20});
    cyc(); #1;
    chk_fetch("f32_lo", 1'b0, 32'h21, 32'h21);
    for (int i = 0; i < 3; i++) begin
      cyc(); stall = 1'b1; #1;
      chk_fetch("stall_hi", 1'b0, 32'h21, 32'h22);
    end
    cyc(); stall = 1'b0; #1;
    chk_fetch("f32_hi", 1'b1, 32'h23, 32'h22);
    exp_q.push_back({32'h4561BEEF, 32'h21});
    cyc(); #1;
    chk_fetch("f16b", 1'b1, 32'h24, 32'h23);
    exp_q.push_back({32'h00000002, 32'h23});

    // Redirect while in FETCH_HI drops the pending high half
    cyc(); #1;
    chk_fetch("rd_lo", 1'b0, 32'h24, 32'h24);
    cyc(); redirect = 1'b1; redirect_pc = 32'h40; #1;
    chk_fetch("rd_hi", 1'b1, 32'h40, 32'h25);
    cyc(); redirect = 1'b0; #1;
    chk_fetch("rd_tgt", 1'b1, 32'h41, 32'h40);
    exp_q.push_back({32'h0000ABC0, 32'h40});

    // Redirect and stall together in FETCH: redirect wins
    cyc(); redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h50; #1;
    chk_fetch("rd_stall", 1'b1, 32'h50, 32'h41);
    cyc(); redirect = 1'b0; stall = 1'b0; #1;
    chk_fetch("rd_stall_tgt", 1'b1, 32'h51, 32'h50);
    exp_q.push_back({32'h00000100, 32'h50});
    cyc(); stall = 1'b1; #1;
    chk_fetch("stall_f", 1'b0, 32'h51, 32'h51);

    // Wrap: vector 0xFFFFFFFF, 16-bit there wraps PC to 0
    cyc(); stall = 1'b0; rst = 1'b0;
    mem[8'h00] = 16'hFFFF; mem[8'h01] = 16'hFFFF; mem[8'hFF] = 16'h0002; #1;
    chk("rst2_pc_we", 64'(pc_we), 64'd0);
    cyc(); rst = 1'b1; #1;
    chk_fetch("w_boot0", 1'b0, pc_q, 32'h0);
    cyc(); #1;
    chk_fetch("w_boot1", 1'b1, 32'hFFFFFFFF, 32'h1);
    cyc(); #1;
    chk_fetch("w_f16", 1'b1, 32'h0, 32'hFFFFFFFF);
    exp_q.push_back({32'h00000002, 32'hFFFFFFFF});
    cyc(); #1;
    chk_fetch("w_f32_lo", 1'b0, 32'h0, 32'h0);

    // Reset pulse in the middle of a 32-bit fetch
    cyc(); #1;
    chk("mid_imem_addr", 64'(imem_addr), 64'h1);
    rst = 1'b0; mem[8'hFF] = 16'h1235; #1;
    chk("mid_pc_we", 64'(pc_we), 64'd0);
    chk("mid_instr", 64'(instr), 64'd0);
    chk("mid_instr_pc", 64'(instr_pc), 64'd0);
    chk("mid_valid", 64'(instr_valid), 64'd0);
    chk("mid_imem_addr_boot", 64'(imem_addr), 64'h0);

    // Reboot and a 32-bit fetch whose low half wraps to address 0
    cyc(); rst = 1'b1; #1;
    chk_fetch("r_boot0", 1'b0, pc_q, 32'h0);
    cyc(); #1;
    chk_fetch("r_boot1", 1'b1, 32'hFFFFFFFF, 32'h1);
    cyc(); #1;
    chk_fetch("r_f32_lo", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc(); #1;
    chk_fetch("r_f32_hi", 1'b1, 32'h1, 32'h0);
    exp_q.push_back({32'h1235FFFF, 32'hFFFFFFFF});
    cyc();
    cyc(); #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
